xoodoo_perm_iter: RTL and testbench

- Parametrised iterative Xoodoo permutation engine; successor to the single-round xooround.
- Applies a runtime-selectable number of rounds, 1..12, to a 384-bit state.
- ROUNDS_PER_CYCLE rounds are unrolled per clock.
- Valid/ready handshakes on both sides; optional byte-order conversion between the Xoodyak byte string and Xoodoo lanes.
- Sits under the absorb/encrypt/squeeze datapath as the shared permutation.

---
 rtl/xoodoo_pkg.sv | 38 +++
 rtl/xoodoo_perm_iter_if.sv | 21 ++
 rtl/xoodoo_round.sv | 43 ++++
 rtl/xoodoo_perm_iter.sv | 97 +++++++++
 tb/tb_xoodoo_perm_iter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xoodoo_pkg.sv
// Shared types, round constants and lane-mapping helpers for the Xoodoo
// permutation engine.
package xoodoo_pkg;

  typedef logic [2:0][3:0][31:0] xoodoo_state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [31:0] XOODOO_RC [12] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // 0 or anything above 12 selects the full permutation
  function automatic logic [3:0] eff_rounds(input logic [3:0] r);
    return (r == 4'd0 || r > 4'd12) ? 4'd12 : r;
  endfunction

  // Byte-string order is a plain byte reversal of the packed lane vector
  function automatic xoodoo_state_t to_lanes(input logic [383:0] s, input bit bo);
    logic [383:0] r;
    if (bo) r = {<<8{s}};
    else    r = s;
    return xoodoo_state_t'(r);
  endfunction

  function automatic logic [383:0] from_lanes(input xoodoo_state_t a, input bit bo);
    logic [383:0] r;
    if (bo) r = {<<8{a}};
    else    r = a;
    return r;
  endfunction

endpackage

// File: rtl/xoodoo_perm_iter_if.sv
// Producer/consumer handshake bundle around the Xoodoo permutation engine.
interface xoodoo_perm_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [383:0] state_in;
  logic [3:0]   in_rounds;
  logic         out_valid;
  logic         out_ready;
  logic [383:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, in_rounds, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, in_rounds, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round; i_en=0 passes the state through unchanged.
module xoodoo_round
  import xoodoo_pkg::*;
(
  input  xoodoo_state_t i_state,
  input  logic [31:0]   i_rc,
  input  logic          i_en,
  output xoodoo_state_t o_state
);

  logic [3:0][31:0] w_p;
  logic [3:0][31:0] w_e;
  xoodoo_state_t    w_t;
  xoodoo_state_t    w_w;
  xoodoo_state_t    w_c;
  xoodoo_state_t    w_o;

  for (genvar x = 0; x < 4; x++) begin : g_col
    assign w_p[x] = i_state[0][x] ^ i_state[1][x] ^ i_state[2][x];
    assign w_e[x] = rotl32(w_p[(x+3)%4], 5) ^ rotl32(w_p[(x+3)%4], 14);

    for (genvar y = 0; y < 3; y++) begin : g_row
      assign w_t[y][x] = i_state[y][x] ^ w_e[x];
      assign w_c[y][x] = w_w[y][x] ^ (~w_w[(y+1)%3][x] & w_w[(y+2)%3][x]);
    end

    // rho-west with iota folded into plane 0, lane 0
    if (x == 0) begin : g_iota
      assign w_w[0][x] = w_t[0][x] ^ i_rc;
    end else begin : g_plain
      assign w_w[0][x] = w_t[0][x];
    end
    assign w_w[1][x] = w_t[1][(x+3)%4];
    assign w_w[2][x] = rotl32(w_t[2][x], 11);

    assign w_o[0][x] = w_c[0][x];
    assign w_o[1][x] = rotl32(w_c[1][x], 1);
    assign w_o[2][x] = rotl32(w_c[2][(x+2)%4], 8);
  end

  assign o_state = i_en ? w_o : i_state;

endmodule

// File: rtl/xoodoo_perm_iter.sv
// Iterative Xoodoo permutation: 1..12 rounds, ROUNDS_PER_CYCLE unrolled per
// clock, valid/ready on both sides.
module xoodoo_perm_iter
  import xoodoo_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter bit          BYTE_ORDER       = 1'b1
) (
  input logic               eph1,
  input logic               reset,
  xoodoo_perm_iter_if.slave bus
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 3 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 6 || ROUNDS_PER_CYCLE == 12)) begin : g_bad_rpc
    $error("xoodoo_perm_iter: ROUNDS_PER_CYCLE must be 1, 2, 3, 4, 6 or 12");
  end

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  xoodoo_state_t r_state;
  logic [4:0]    r_rnd_idx;
  logic [4:0]    w_idx_nxt;
  logic          w_in_ready;
  logic          w_accept;
  xoodoo_state_t w_last;

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_idx_nxt = r_rnd_idx + 5'(ROUNDS_PER_CYCLE);

  // Stages past the last table entry bypass, so short round counts finish mid-chain
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_stage
    xoodoo_state_t w_in;
    xoodoo_state_t w_out;
    logic [5:0]    w_idx;
    logic          w_en;
    logic [31:0]   w_rc;

    if (k == 0) begin : g_first
      assign w_in = r_state;
    end else begin : g_next
      assign w_in = g_stage[k-1].w_out;
    end

    assign w_idx = {1'b0, r_rnd_idx} + 6'(k);
    assign w_en  = (w_idx < 6'd12);
    assign w_rc  = w_en ? XOODOO_RC[w_idx[3:0]] : '0;

    xoodoo_round u_round (
      .i_state (w_in),
      .i_rc    (w_rc),
      .i_en    (w_en),
      .o_state (w_out)
    );
  end

  assign w_last = g_stage[ROUNDS_PER_CYCLE-1].w_out;

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: if (w_accept) w_fsm_nxt = RUN;
      RUN:  if (w_idx_nxt >= 5'd12) w_fsm_nxt = DONE;
      DONE: if (bus.out_ready) w_fsm_nxt = bus.in_valid ? RUN : IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready    = (r_fsm == IDLE) | ((r_fsm == DONE) & bus.out_ready);
    bus.out_valid = (r_fsm == DONE);
    bus.busy      = (r_fsm == RUN);
  end

  assign bus.in_ready = w_in_ready;

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      r_state   <= '0;
      r_rnd_idx <= '0;
    end else if (w_accept) begin
      r_state   <= to_lanes(bus.state_in, BYTE_ORDER);
      r_rnd_idx <= 5'd12 - {1'b0, eff_rounds(bus.in_rounds)};
    end else if (r_fsm == RUN) begin
      r_state   <= w_last;
      r_rnd_idx <= w_idx_nxt;
    end
  end

  assign bus.state_out = from_lanes(r_state, BYTE_ORDER);

endmodule

// File: tb/tb_xoodoo_perm_iter.sv
// Bench for xoodoo_perm_iter: four parameterisations driven in parallel and
// compared against an array-based Xoodoo reference model.
`timescale 1ns/1ps
module tb_xoodoo_perm_iter;

  localparam int unsigned RPC_T [4] = '{1, 1, 4, 12};
  localparam bit          BO_T  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [31:0] RC_T [12] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   iv = '0;
  logic [3:0]   ordy = '0;
  logic [383:0] sin = '0;
  logic [3:0]   rin = '0;
  logic [3:0]   ov, ir, bz;
  logic [383:0] sout [4];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    xoodoo_perm_iter_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.out_ready = ordy[g];
    assign bus.state_in  = sin;
    assign bus.in_rounds = rin;
    assign ov[g]   = bus.out_valid;
    assign ir[g]   = bus.in_ready;
    assign bz[g]   = bus.busy;
    assign sout[g] = bus.state_out;

    xoodoo_perm_iter #(
      .ROUNDS_PER_CYCLE (RPC_T[g]),
      .BYTE_ORDER       (BO_T[g])
    ) u_dut (
      .eph1  (clk),
      .reset (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [383:0]       st;
    logic [3:0]         rnd;
    logic [3:0][4:0]    lat;
    logic [3:0][383:0]  exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input bit ok, input string nm, input int d,
                     input logic [383:0] act, input logic [383:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, d, act, req);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
  endfunction

  // Reference: lanes as a 3x4 word array, rounds applied straight from the round definition
  function automatic logic [383:0] ref_perm(input logic [383:0] s, input logic [3:0] rn, input bit bo);
    logic [31:0]  a [3][4];
    logic [31:0]  b [3][4];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [383:0] r;
    int           nr;
    nr = (rn == 0 || rn > 12) ? 12 : int'(rn);
    for (int i = 0; i < 12; i++) begin
      if (bo) for (int k = 0; k < 4; k++) a[i/4][i%4][8*k +: 8] = s[383 - 8*(4*i+k) -: 8];
      else    a[i/4][i%4] = s[32*i +: 32];
    end
    for (int rr = 12 - nr; rr < 12; rr++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
      b = a;
      for (int x = 0; x < 4; x++) begin
        a[1][x] = b[1][(x+3)%4];
        a[2][x] = rl(b[2][x], 11);
      end
      a[0][0] ^= RC_T[rr];
      b = a;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++)
        a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
      b = a;
      for (int x = 0; x < 4; x++) begin
        a[1][x] = rl(b[1][x], 1);
        a[2][x] = rl(b[2][(x+2)%4], 8);
      end
    end
    r = '0;
    for (int i = 0; i < 12; i++) begin
      if (bo) for (int k = 0; k < 4; k++) r[383 - 8*(4*i+k) -: 8] = a[i/4][i%4][8*k +: 8];
      else    r[32*i +: 32] = a[i/4][i%4];
    end
    return r;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [3:0][383:0] exp_all(input logic [383:0] s, input logic [3:0] rn);
    logic [3:0][383:0] e;
    for (int d = 0; d < 4; d++) e[d] = ref_perm(s, rn, BO_T[d]);
    return e;
  endfunction

  function automatic logic [3:0][4:0] lat_all(input logic [3:0] rn);
    logic [3:0][4:0] l;
    int nr;
    nr = (rn == 0 || rn > 12) ? 12 : int'(rn);
    for (int d = 0; d < 4; d++) l[d] = 5'((nr + int'(RPC_T[d]) - 1) / int'(RPC_T[d]));
    return l;
  endfunction

  task automatic launch(input logic [3:0] mask, input logic [383:0] st, input logic [3:0] rn);
    @(negedge clk);
    sin = st; rin = rn; iv = mask;
    #1;
    for (int d = 0; d < 4; d++) if (mask[d]) chk(ir[d] == 1'b1, "launch_inready", d, ir[d], 1);
    @(posedge clk); #1;
    iv = '0;
  endtask

  task automatic wait_done(input logic [3:0] mask, input logic [3:0][4:0] lat,
                           input logic [3:0][383:0] exp, input bit tog, input string nm);
    int         got [4];
    logic [3:0] seen;
    int         cyc;
    seen = '0; cyc = 0;
    for (int d = 0; d < 4; d++) got[d] = 0;
    while (((seen & mask) != mask) && cyc < 30) begin
      if (tog) begin
        @(negedge clk);
        iv  = cyc[0] ? 4'hF : 4'h0;
        sin = rand384();
        rin = 4'($urandom_range(0, 15));
        #1;
        for (int d = 0; d < 4; d++) if (mask[d]) chk(ir[d] == 1'b0, {nm, "_inready_busy"}, d, ir[d], 0);
      end
      @(posedge clk); #1;
      cyc++;
      for (int d = 0; d < 4; d++)
        if (mask[d] && !seen[d] && ov[d]) begin seen[d] = 1'b1; got[d] = cyc; end
    end
    iv = '0;
    for (int d = 0; d < 4; d++) if (mask[d]) begin
      chk(got[d] == int'(lat[d]), {nm, "_latency"}, d, 384'(got[d]), 384'(lat[d]));
      chk(sout[d] == exp[d], {nm, "_state"}, d, sout[d], exp[d]);
    end
  endtask

  task automatic drain(input logic [3:0] mask);
    @(negedge clk);
    ordy = mask;
    @(posedge clk); #1;
    ordy = '0;
    for (int d = 0; d < 4; d++) if (mask[d]) chk(ov[d] == 1'b0, "drain_outvalid", d, ov[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [383:0]      st, st2, k;
    logic [3:0][383:0] e;
    logic [3:0][4:0]   l;
    logic [3:0]        rn;

    vt[0] = '{st: '0,        rnd: 4'd12, lat: {5'd1, 5'd3, 5'd12, 5'd12}, exp: '0};
    vt[1] = '{st: rand384(), rnd: 4'd1,  lat: {5'd1, 5'd1, 5'd1,  5'd1},  exp: '0};
    vt[2] = '{st: rand384(), rnd: 4'd0,  lat: {5'd1, 5'd3, 5'd12, 5'd12}, exp: '0};
    vt[3] = '{st: rand384(), rnd: 4'd13, lat: {5'd1, 5'd3, 5'd12, 5'd12}, exp: '0};
    vt[4] = '{st: rand384(), rnd: 4'd5,  lat: {5'd1, 5'd2, 5'd5,  5'd5},  exp: '0};
    vt[5] = '{st: rand384(), rnd: 4'd7,  lat: {5'd1, 5'd2, 5'd7,  5'd7},  exp: '0};
    vt[6] = '{st: rand384(), rnd: 4'd15, lat: {5'd1, 5'd3, 5'd12, 5'd12}, exp: '0};
    vt[7] = '{st: rand384(), rnd: 4'd8,  lat: {5'd1, 5'd2, 5'd8,  5'd8},  exp: '0};
    for (int i = 0; i < 8; i++) vt[i].exp = exp_all(vt[i].st, vt[i].rnd);

    #12;
    for (int d = 0; d < 4; d++) begin
      chk(ov[d] == 1'b0, "reset_outvalid", d, ov[d], 0);
      chk(bz[d] == 1'b0, "reset_busy", d, bz[d], 0);
      chk(sout[d] == '0, "reset_state", d, sout[d], '0);
      chk(ir[d] == 1'b1, "reset_inready", d, ir[d], 1);
    end
    @(negedge clk); rst_n = 1'b1;

    k = '0; k[31:0] = 32'h12; k[159:128] = 32'h24;
    e = '0; e[0] = k; l = '0; l[0] = 5'd1;
    launch(4'h1, '0, 4'd1);
    wait_done(4'h1, l, e, 1'b0, "lane_const");
    drain(4'h1);

    for (int i = 0; i < 8; i++) begin
      launch(4'hF, vt[i].st, vt[i].rnd);
      wait_done(4'hF, vt[i].lat, vt[i].exp, 1'b0, "vec");
      drain(4'hF);
    end

    for (int i = 0; i < 50; i++) begin
      st = rand384();
      launch(4'hF, st, 4'd12);
      wait_done(4'hF, lat_all(4'd12), exp_all(st, 4'd12), 1'b0, "rand12");
      drain(4'hF);
    end
    for (int i = 0; i < 20; i++) begin
      st = rand384();
      rn = 4'($urandom_range(0, 15));
      launch(4'hF, st, rn);
      wait_done(4'hF, lat_all(rn), exp_all(st, rn), 1'b0, "randr");
      drain(4'hF);
    end

    st = rand384();
    e  = exp_all(st, 4'd12);
    launch(4'hF, st, 4'd12);
    wait_done(4'hF, lat_all(4'd12), e, 1'b0, "stall_first");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        chk(ov[d] == 1'b1, "stall_outvalid", d, ov[d], 1);
        chk(sout[d] == e[d], "stall_state", d, sout[d], e[d]);
        chk(ir[d] == 1'b0, "stall_inready", d, ir[d], 0);
      end
    end
    st2 = rand384();
    @(negedge clk);
    sin = st2; rin = 4'd12; iv = 4'b0010; ordy = 4'b0010;
    #1;
    chk(ir[1] == 1'b1, "handoff_inready", 1, ir[1], 1);
    @(posedge clk); #1;
    iv = '0; ordy = '0;
    chk(bz[1] == 1'b1, "handoff_busy", 1, bz[1], 1);
    chk(ov[1] == 1'b0, "handoff_outvalid", 1, ov[1], 0);
    wait_done(4'b0010, lat_all(4'd12), exp_all(st2, 4'd12), 1'b0, "handoff_second");
    drain(4'hF);

    st = rand384();
    launch(4'hF, st, 4'd12);
    wait_done(4'hF, lat_all(4'd12), exp_all(st, 4'd12), 1'b1, "toggle");
    drain(4'hF);

    st = rand384();
    launch(4'hF, st, 4'd12);
    repeat (4) @(posedge clk);
    #2;
    chk(bz[1] == 1'b1, "prereset_busy", 1, bz[1], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk(ov[d] == 1'b0, "midreset_outvalid", d, ov[d], 0);
      chk(bz[d] == 1'b0, "midreset_busy", d, bz[d], 0);
      chk(sout[d] == '0, "midreset_state", d, sout[d], '0);
    end
    @(negedge clk); rst_n = 1'b1;
    st2 = rand384();
    launch(4'hF, st2, 4'd12);
    wait_done(4'hF, lat_all(4'd12), exp_all(st2, 4'd12), 1'b0, "postreset");
    drain(4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
